// File: rtl/keypad_scan_ctrl.sv
// Column-strobing scanner and press/release debouncer for a 4x4 active-low key matrix.
// Locks onto one key, reports it once, and resumes scanning only after a clean release.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] KEY_R,
   output logic [3:0] KEY_C,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [1:0] scan_col
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CYC);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t           state, state_nx;
   logic [3:0]       row_m, row_s;
   logic [3:0]       row_lat, row_lat_nx;
   logic [DIV_W-1:0] div, div_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       col_nx;
   logic [3:0]       code_nx;
   logic             valid_nx, held_nx;

   // Lowest-numbered low row wins when several rows are pulled down at once.
   function automatic logic [1:0] lowest_zero(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m <= 4'hF;
         row_s <= 4'hF;
      end else begin
         row_m <= KEY_R;
         row_s <= row_m;
      end
   end

   always_comb begin
      state_nx   = state;
      div_nx     = div;
      cnt_nx     = cnt;
      col_nx     = scan_col;
      row_lat_nx = row_lat;
      code_nx    = key_code;
      valid_nx   = 1'b0;
      held_nx    = key_held;
      case (state)
         SCAN: begin
            if (div == DIV_LAST) begin
               div_nx = '0;
               if (row_s == 4'hF) begin
                  col_nx = scan_col + 2'd1;
               end else begin
                  row_lat_nx = row_s;
                  cnt_nx     = '0;
                  state_nx   = DEBOUNCE;
               end
            end else begin
               div_nx = div + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (row_s != row_lat) begin
               state_nx = SCAN;
               div_nx   = '0;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
               valid_nx = 1'b1;
               held_nx  = 1'b1;
               code_nx  = {lowest_zero(row_lat), scan_col};
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (row_s == 4'hF) begin
               state_nx = RELEASE;
               cnt_nx   = '0;
            end
         end
         RELEASE: begin
            // Any bounce back to a pressed row restarts the release count.
            if (row_s != 4'hF) begin
               cnt_nx = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = SCAN;
               held_nx  = 1'b0;
               col_nx   = scan_col + 2'd1;
               div_nx   = '0;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         div       <= '0;
         cnt       <= '0;
         scan_col  <= 2'd0;
         KEY_C     <= 4'b1110;
         row_lat   <= 4'hF;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nx;
         div       <= div_nx;
         cnt       <= cnt_nx;
         scan_col  <= col_nx;
         KEY_C     <= ~(4'b0001 << col_nx);
         row_lat   <= row_lat_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
         key_held  <= held_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a key-matrix model feeds the scanner, a scoreboard
// queue holds the events each press should produce and a monitor checks them.
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int LAT_MAX  = SCAN_DIV * 4 + 2 + DEB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] KEY_R;
   logic [3:0] KEY_C;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [1:0] scan_col;

   logic [15:0] pressed_map = '0;   // bit r*4+c = switch at row r, column c closed
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [3:0]  last_code = 4'd0;
   logic        prev_held = 1'b0;
   logic [3:0]  mon_exp_c;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
      .clk(clk), .rst(rst), .KEY_R(KEY_R), .KEY_C(KEY_C), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .scan_col(scan_col)
   );

   // Passive matrix: a closed switch pulls its row low while its column is strobed.
   always_comb begin
      KEY_R = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed_map[r*4+c] && !KEY_C[c]) KEY_R[r] = 1'b0;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         last_code = 4'd0;
         prev_held = 1'b0;
      end else begin
         mon_exp_c = ~(4'b0001 << scan_col);
         check("col_strobe", 8'(KEY_C), 8'(mon_exp_c));
         if (key_valid) begin
            check("valid_while_held", 8'(prev_held), 8'(0));
            check("held_with_valid", 8'(key_held), 8'(1));
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: key_code %0d, expected no event (cycle %0d)", key_code, cyc);
            end else begin
               mon_e = sb.pop_front();
               check("key_code", 8'(key_code), 8'(mon_e.code));
               if (cyc - mon_e.cyc > LAT_MAX) begin
                  n_fail++;
                  $display("FAIL latency: got %0d cycles, required <= %0d", cyc - mon_e.cyc, LAT_MAX);
               end
            end
            last_code = key_code;
         end else begin
            check("code_stable", 8'(key_code), 8'(last_code));
         end
         if (prev_held && !key_held)
            check("resume_col", 8'(scan_col), 8'(2'(last_code[1:0] + 2'd1)));
         prev_held = key_held;
      end
   end

   task automatic drain(input string name);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected events not seen, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic press_keys(input logic [15:0] keys, input logic [3:0] code, input int hold);
      sb.push_back('{code: code, cyc: cyc});
      pressed_map = pressed_map | keys;
      tick(hold);
      drain("press_event");
      check("held_after_press", 8'(key_held), 8'(1));
   endtask

   // Sync (2) plus 8 clean samples; from PRESSED one extra sample is spent leaving that state.
   task automatic release_keys(input logic [15:0] keys, input bit bounce);
      int fall;
      pressed_map = pressed_map & ~keys;
      if (bounce) begin
         repeat (2) begin
            tick(3);
            pressed_map = pressed_map | keys;
            tick(2);
            pressed_map = pressed_map & ~keys;
         end
      end
      fall = bounce ? 10 : 11;
      tick(fall - 1);
      check("held_before_debounce", 8'(key_held), 8'(1));
      tick(1);
      check("held_after_debounce", 8'(key_held), 8'(0));
   endtask

   task automatic glitch(input logic [15:0] keys, input int len);
      pressed_map = pressed_map | keys;
      tick(len);
      pressed_map = pressed_map & ~keys;
      tick(20);
      check("glitch_no_hold", 8'(key_held), 8'(0));
   endtask

   initial begin
      int kind, r, c, r2, c2, hold;
      logic [15:0] k1, k2;
      logic [3:0] ec;

      repeat (3) @(posedge clk);
      #2;
      check("rst_key_c", 8'(KEY_C), 8'(4'b1110));
      check("rst_valid", 8'(key_valid), 8'(0));
      check("rst_code", 8'(key_code), 8'(0));
      check("rst_held", 8'(key_held), 8'(0));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(i == 0 ? 2 : 4);
         ec = ~(4'b0001 << (i % 4));
         check("scan_step", 8'(KEY_C), 8'(ec));
      end

      press_keys(16'h0040, 4'd6, 40);              // row1/col2
      release_keys(16'h0040, 1'b0);
      glitch(16'h0001, 3);                          // row0/col0 short tap
      press_keys(16'h0200, 4'd9, 1000);            // row2/col1 long hold
      release_keys(16'h0200, 1'b1);
      press_keys(16'h0808, 4'd3, 40);              // rows 0 and 2 on col3
      pressed_map = pressed_map | 16'h0010;         // row1/col0 while locked
      tick(20);
      pressed_map = pressed_map & ~16'h0010;
      tick(2);
      release_keys(16'h0808, 1'b0);

      press_keys(16'h0020, 4'd5, 40);              // row1/col1, then reset while held
      #2;
      rst = 1'b1;
      #1;
      check("midrst_key_c", 8'(KEY_C), 8'(4'b1110));
      check("midrst_held", 8'(key_held), 8'(0));
      check("midrst_valid", 8'(key_valid), 8'(0));
      check("midrst_code", 8'(key_code), 8'(0));
      check("midrst_col", 8'(scan_col), 8'(0));
      tick(2);
      rst = 1'b0;
      sb.push_back('{code: 4'd5, cyc: cyc});
      tick(40);
      drain("rereport_event");
      check("held_after_rereport", 8'(key_held), 8'(1));
      release_keys(16'h0020, 1'b0);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 4);
         r    = $urandom_range(0, 3);
         c    = $urandom_range(0, 3);
         hold = 30 + $urandom_range(0, 40);
         k1   = 16'h0001 << (r * 4 + c);
         case (kind)
            0, 1: begin
               press_keys(k1, 4'(r * 4 + c), hold);
               release_keys(k1, kind == 1);
            end
            2: begin
               r2 = (r + 1 + $urandom_range(0, 2)) % 4;
               k2 = 16'h0001 << (r2 * 4 + c);
               press_keys(k1 | k2, 4'(((r < r2) ? r : r2) * 4 + c), hold);
               release_keys(k1 | k2, 1'b0);
            end
            3: glitch(k1, $urandom_range(1, 6));
            default: begin
               c2 = (c + 1 + $urandom_range(0, 2)) % 4;
               k2 = 16'h0001 << ($urandom_range(0, 3) * 4 + c2);
               press_keys(k1, 4'(r * 4 + c), hold);
               pressed_map = pressed_map | k2;
               tick(15);
               pressed_map = pressed_map & ~k2;
               tick(2);
               release_keys(k1, 1'b0);
            end
         endcase
      end

      tick(5);
      drain("final_drain");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
